sdp_ram_param: RTL and testbench
================================

SDP_RAM_PARAM -- requirements
Module: sdp_ram_param

Interface
REQ-001 Parameter DATA_W, default 64: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 512: number of words; SHALL be a power of two, minimum 4.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH) (9): address width.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles; only 1 or 2 legal.
REQ-005 Parameter CLR_ON_RST, default 1: 1 enables the post-reset memory clear sequence.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 Port rst_n, input, 1: synchronous active-low reset.
REQ-009 Port wea, input, 1: write request.
REQ-010 Port addra, input, ADDR_W: write address.
REQ-011 Port bea, input, DATA_W/8: byte enables; bit i covers dina[8i+7:8i].
REQ-012 Port dina, input, DATA_W: write data.
REQ-013 Port reb, input, 1: read request.
REQ-014 Port addrb, input, ADDR_W: read address.
REQ-015 Port doutb, output, DATA_W: registered read data.
REQ-016 Port validb, output, 1: doutb holds the result of a read request this cycle.
REQ-017 Port busy, output, 1: clear sequence in progress; port requests ignored.

Function
REQ-018 FSM states: CLEAR, READY; from reset: CLEAR if CLR_ON_RST=1, else READY.
REQ-019 CLEAR: internal counter steps 0..DEPTH-1, writing all-zero to one word per cycle; on the cycle word DEPTH-1 is written, the FSM goes to READY.
REQ-020 Clear takes exactly DEPTH cycles after rst_n deasserts; busy=1 throughout; busy=0 from the first READY cycle.
REQ-021 In CLEAR, wea and reb SHALL be ignored; no memory write from port A and no validb pulse.
REQ-022 READY write: wea=1 updates only the bytes of mem[addra] whose bea bit is 1; bea=0 with wea=1 leaves the word unchanged.
REQ-023 READY read: reb=1 at cycle N gives doutb=mem[addrb] and validb=1 at cycle N+RD_LAT; no stall; one read accepted per cycle.
REQ-024 Back-to-back reads SHALL give back-to-back validb pulses in request order.
REQ-025 When no read completes in a cycle, validb=0 and doutb holds its last value.
REQ-026 Collision: wea=1 and reb=1 with addra==addrb in the same cycle is write-first; read data = enabled bytes from dina, remaining bytes from the old word.
REQ-027 A read issued the cycle after a write to the same address SHALL return the written data (no stale read at either RD_LAT).
REQ-028 Addresses are ADDR_W bits wide and fully decoded; no out-of-range case exists.
REQ-029 With RD_LAT=2, the second pipeline stage SHALL be a plain register of the first; validb delays match data delays.

Reset
REQ-030 rst_n=0 at a clock edge: validb=0, doutb=0, read pipeline flushed, clear counter=0, FSM to its reset state; busy=1 if CLR_ON_RST=1, else 0.
REQ-031 Reset does not change memory contents directly; with CLR_ON_RST=1 the contents are zeroed by the following clear sequence.
REQ-032 Reset during CLEAR restarts the clear from address 0; reset during READY drops any in-flight read without a validb pulse.
REQ-033 With CLR_ON_RST=0, memory contents after power-up are undefined in simulation (X) until written.

Verification
REQ-034 Clear: DATA_W=64, DEPTH=512, release rst_n -> busy=1 for exactly 512 cycles; then a read of every address returns 0.
REQ-035 Byte write: write 0x1122334455667788 with bea=0xFF to addr 5, then 0xAAAAAAAAAAAAAAAA with bea=0x0F -> read addr 5 returns 0x11223344AAAAAAAA.
REQ-036 Collision: in one cycle, wea=1, addra=7, dina=0xDEAD, bea=0xFF, plus reb=1, addrb=7 -> doutb=0xDEAD with validb=1 after RD_LAT cycles (check RD_LAT=1 and RD_LAT=2).
REQ-037 Streaming: reb=1 for 8 cycles on addresses 0..7 holding data k*3 -> 8 consecutive validb pulses with data 0,3,...,21; validb drops the cycle after.
REQ-038 Busy lockout: wea=1 to addr 3 and reb=1 during CLEAR -> no validb; after clear, addr 3 reads 0.
REQ-039 Reset mid-read: reb=1, then rst_n=0 on the next edge with RD_LAT=2 -> no validb pulse and doutb=0; clear restarts and busy=1 for 512 cycles.

Source files
------------

// File: rtl/sdp_ram_param_if.sv
// Port bundle for sdp_ram_param: write port A, read port B and the busy flag.
interface sdp_ram_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
);
  logic                  wea;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W/8-1:0]   bea;
  logic [DATA_W-1:0]     dina;
  logic                  reb;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W-1:0]     doutb;
  logic                  validb;
  logic                  busy;

  modport master (
    output wea, addra, bea, dina, reb, addrb,
    input  doutb, validb, busy
  );

  modport slave (
    input  wea, addra, bea, dina, reb, addrb,
    output doutb, validb, busy
  );
endinterface

// File: rtl/sdp_ram_param.sv
// Simple dual-port RAM: byte-enabled write port A, pipelined read port B
// (latency 1 or 2), write-first on same-address collision, optional
// post-reset sequential clear during which both ports are locked out.
module sdp_ram_param #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sdp_ram_param_if.slave bus
);

  localparam int NBYTES = DATA_W / 8;

  // Elaboration-time parameter sanity checks.
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $error("sdp_ram_param: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sdp_ram_param: DEPTH must be a power of two, at least 4");
  end
  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr
    $error("sdp_ram_param: ADDR_W must equal clog2(DEPTH)");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("sdp_ram_param: RD_LAT must be 1 or 2");
  end

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_last;
  logic                clr_we;
  logic                port_we;
  logic                rd_acc;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;

  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign bus.busy = (state == CLEAR);

  // State register; reset lands in CLEAR only when the clear sequence is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLR_ON_RST != 0) ? CLEAR : READY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle enables; nothing acts while rst_n is low.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    port_we   = 1'b0;
    rd_acc    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we = rst_n;
        if (rst_n && clr_last) begin
          state_nxt = READY;
        end
      end
      READY: begin
        port_we = rst_n & bus.wea;
        rd_acc  = rst_n & bus.reb;
      end
      default: state_nxt = state;
    endcase
  end

  // Clear address counter; wraps back to 0 as the last word is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (clr_we) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Read word with same-cycle write bytes forwarded over the stored word.
  always_comb begin
    rd_word = mem[bus.addrb];
    if (port_we && (bus.addra == bus.addrb)) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (bus.bea[i]) begin
          rd_word[8*i +: 8] = bus.dina[8*i +: 8];
        end
      end
    end
  end

  // Memory array: clear writes take the port's place while busy; no reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (port_we) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (bus.bea[i]) begin
          mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
        end
      end
    end
  end

  // First read stage: data loads only on an accepted read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    // Second stage is a plain copy of the first; holding falls out of s1 holding.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
      end
    end

    assign bus.validb = s2_valid;
    assign bus.doutb  = s2_data;
  end else begin : g_lat1
    assign bus.validb = s1_valid;
    assign bus.doutb  = s1_data;
  end

endmodule

// File: tb/tb_sdp_ram_param.sv
// Bench for sdp_ram_param: two instances (read latency 1 and 2) share one
// stimulus stream; a queue-based model is compared every cycle and directed
// literal checks pin the main scenarios.
module tb_sdp_ram_param;

  localparam int DW = 64;
  localparam int DP = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wea;
  logic [AW-1:0] addra;
  logic [7:0]    bea;
  logic [DW-1:0] dina;
  logic          reb;
  logic [AW-1:0] addrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdp_ram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  sdp_ram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  assign bus1.wea = wea;  assign bus1.addra = addra; assign bus1.bea = bea;
  assign bus1.dina = dina; assign bus1.reb = reb;   assign bus1.addrb = addrb;
  assign bus2.wea = wea;  assign bus2.addra = addra; assign bus2.bea = bea;
  assign bus2.dina = dina; assign bus2.reb = reb;   assign bus2.addrb = addrb;

  sdp_ram_param #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RD_LAT(1), .CLR_ON_RST(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sdp_ram_param #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RD_LAT(2), .CLR_ON_RST(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    longint unsigned due;
    logic [63:0]     d;
  } rd_t;

  logic [63:0]     mmem [DP];
  rd_t             q1[$];
  rd_t             q2[$];
  longint unsigned edge_n = 0;
  int              clr_left = 0;
  logic            started = 1'b0;
  logic            ev1 = 1'b0, ev2 = 1'b0, eb = 1'b0;
  logic [63:0]     ed1 = '0, ed2 = '0;

  always @(posedge clk) begin
    logic [63:0] v;
    edge_n++;
    ev1 = 1'b0;
    ev2 = 1'b0;
    if (!rst_n) begin
      clr_left = DP;
      q1.delete();
      q2.delete();
      ed1 = '0;
      ed2 = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) for (int i = 0; i < DP; i++) mmem[i] = '0;
    end else begin
      if (reb) begin
        v = mmem[addrb];
        if (wea && addra == addrb) v = merge(v, dina, bea);
        q1.push_back('{edge_n, v});
        q2.push_back('{edge_n + 1, v});
      end
      if (wea) mmem[addra] = merge(mmem[addra], dina, bea);
    end
    if (q1.size() > 0 && q1[0].due == edge_n) begin
      ev1 = 1'b1; ed1 = q1[0].d; void'(q1.pop_front());
    end
    if (q2.size() > 0 && q2[0].due == edge_n) begin
      ev2 = 1'b1; ed2 = q2[0].d; void'(q2.pop_front());
    end
    eb = (clr_left > 0);
    started = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("m_validb1", {63'd0, bus1.validb}, {63'd0, ev1});
      check("m_validb2", {63'd0, bus2.validb}, {63'd0, ev2});
      check("m_doutb1", bus1.doutb, ed1);
      check("m_doutb2", bus2.doutb, ed2);
      check("m_busy1", {63'd0, bus1.busy}, {63'd0, eb});
      check("m_busy2", {63'd0, bus2.busy}, {63'd0, eb});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; reb = 1'b0; addra = '0; addrb = '0; bea = '0; dina = '0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle();
    tick(); tick();
    check("rst_busy", {63'd0, bus1.busy}, 64'd1);
    check("rst_validb", {63'd0, bus1.validb}, 64'd0);
    check("rst_doutb", bus2.doutb, 64'd0);

    // Clear length with port requests to addr 3 during the first cycles.
    rst_n = 1'b1;
    wea = 1'b1; addra = 9'd3; dina = '1; bea = 8'hFF;
    reb = 1'b1; addrb = 9'd3;
    n = 0;
    while (bus1.busy && n < 600) begin
      tick();
      n++;
      if (n == 10) idle();
    end
    idle();
    check("clear_len", 64'(n), 64'd512);
    check("clear_busy2", {63'd0, bus2.busy}, 64'd0);

    // Every address reads zero after the clear.
    for (int i = 0; i < DP; i++) begin
      reb = 1'b1; addrb = AW'(i);
      tick();
      check("clr_rd", bus1.doutb, 64'd0);
    end
    idle();
    tick(); tick();

    // Byte-enabled writes.
    wea = 1'b1; addra = 9'd5; dina = 64'h1122334455667788; bea = 8'hFF; tick();
    dina = 64'hAAAAAAAAAAAAAAAA; bea = 8'h0F; tick();
    dina = 64'h0; bea = 8'h00; tick();
    idle(); reb = 1'b1; addrb = 9'd5; tick();
    idle(); tick();
    check("bytewr1", bus1.doutb, 64'h11223344AAAAAAAA);
    check("bytewr2", bus2.doutb, 64'h11223344AAAAAAAA);

    // Full collision, then partial collision.
    wea = 1'b1; addra = 9'd7; dina = 64'hDEAD; bea = 8'hFF; reb = 1'b1; addrb = 9'd7;
    tick();
    idle();
    check("coll_v1", {63'd0, bus1.validb}, 64'd1);
    check("coll_d1", bus1.doutb, 64'hDEAD);
    check("coll_v2_early", {63'd0, bus2.validb}, 64'd0);
    tick();
    check("coll_v2", {63'd0, bus2.validb}, 64'd1);
    check("coll_d2", bus2.doutb, 64'hDEAD);
    check("coll_v1_drop", {63'd0, bus1.validb}, 64'd0);
    wea = 1'b1; addra = 9'd7; dina = '1; bea = 8'h02; reb = 1'b1; addrb = 9'd7;
    tick();
    idle();
    check("pcoll_d1", bus1.doutb, 64'h000000000000FFAD);
    tick();

    // Read the cycle after a write.
    wea = 1'b1; addra = 9'd9; dina = 64'h0123456789ABCDEF; bea = 8'hFF; tick();
    idle(); reb = 1'b1; addrb = 9'd9; tick();
    idle();
    check("raw_d1", bus1.doutb, 64'h0123456789ABCDEF);
    tick();
    check("raw_d2", bus2.doutb, 64'h0123456789ABCDEF);

    // Streaming reads of k*3.
    for (int k = 0; k < 8; k++) begin
      wea = 1'b1; addra = AW'(k); dina = 64'(k * 3); bea = 8'hFF; tick();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      reb = 1'b1; addrb = AW'(k); tick();
      check("stream_v1", {63'd0, bus1.validb}, 64'd1);
      check("stream_d1", bus1.doutb, 64'(k * 3));
    end
    idle(); tick();
    check("stream_drop1", {63'd0, bus1.validb}, 64'd0);
    check("stream_last2", bus2.doutb, 64'd21);
    tick();
    check("stream_drop2", {63'd0, bus2.validb}, 64'd0);

    // Reset while a latency-2 read is in flight.
    reb = 1'b1; addrb = 9'd2; tick();
    idle(); rst_n = 1'b0; tick();
    check("rstrd_v2", {63'd0, bus2.validb}, 64'd0);
    check("rstrd_d2", bus2.doutb, 64'd0);
    check("rstrd_busy", {63'd0, bus2.busy}, 64'd1);
    rst_n = 1'b1;
    n = 0;
    while (bus2.busy && n < 600) begin
      tick();
      n++;
    end
    check("reclear_len", 64'(n), 64'd512);
    reb = 1'b1; addrb = 9'd3; tick();
    idle(); tick();
    check("reclear_rd3", bus2.doutb, 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
